mul_issue_pipe: RTL and testbench

- Pipelined RV32M multiply execute unit. It accepts MUL/MULH/MULHSU/MULHU requests from the decode/issue stage and conditions operands into unsigned magnitudes plus a sign flag.
- It drives the existing combinational unsigned core vedic_mult_32bit (32x32 -> 64), applies the final 64-bit negation, selects the architectural 32-bit word, and hands the result to writeback.
- Two-stage valid/ready pipeline with a throughput of one operation per cycle.

---
 rtl/mul_issue_pipe.sv | 150 +++++++++++++++
 tb/tb_mul_issue_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_pipe.sv
// RV32M multiply execute unit: two-stage valid/ready pipe
// around an unsigned 32x32 vedic multiplier core.

module vedic_mult_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p
);

  logic [31:0] ll;
  logic [31:0] lh;
  logic [31:0] hl;
  logic [31:0] hh;
  logic [63:0] mid;

  // vertical/crosswise split into four 16x16 partials
  always_comb begin
    ll  = a[15:0]  * b[15:0];
    lh  = a[15:0]  * b[31:16];
    hl  = a[31:16] * b[15:0];
    hh  = a[31:16] * b[31:16];
    mid = {32'd0, lh} + {32'd0, hl};
    p   = {hh, ll} + (mid << 16);
  end

endmodule

module mul_issue_pipe #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag
);

  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      mag_a_q, mag_a_d;
  logic [31:0]      mag_b_q, mag_b_d;
  logic             neg_q, neg_d;
  logic [1:0]       op1_q, op1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;

  logic             s2_valid_q, s2_valid_d;
  logic [63:0]      prod_q, prod_d;
  logic [1:0]       op2_q, op2_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;

  logic             s1_load;
  logic             s2_load;
  logic             sign_a;
  logic             sign_b;
  logic [63:0]      p_raw;

  vedic_mult_32bit u_core (
    .a (mag_a_q),
    .b (mag_b_q),
    .p (p_raw)
  );

  // handshake: stage 1 may refill as stage 2 drains
  always_comb begin
    s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
    in_ready = ~s1_valid_q | s2_load;
    s1_load  = in_valid & in_ready;
  end

  // stage 1: sign-condition operands into magnitudes
  always_comb begin
    sign_a  = (in_op != 2'b11) & in_rs1[31];
    sign_b  = ~in_op[1] & in_rs2[31];
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_d   = neg_q;
    op1_d   = op1_q;
    tag1_d  = tag1_q;
    if (s1_load) begin
      mag_a_d = sign_a ? (~in_rs1 + 32'd1) : in_rs1;
      mag_b_d = sign_b ? (~in_rs2 + 32'd1) : in_rs2;
      neg_d   = sign_a ^ sign_b;
      op1_d   = in_op;
      tag1_d  = in_tag;
    end
    s1_valid_d = s1_valid_q;
    if (flush)        s1_valid_d = 1'b0;
    else if (s1_load) s1_valid_d = 1'b1;
    else if (s2_load) s1_valid_d = 1'b0;
  end

  // stage 2: apply final negation to the core product
  always_comb begin
    prod_d = prod_q;
    op2_d  = op2_q;
    tag2_d = tag2_q;
    if (s2_load) begin
      prod_d = neg_q ? (~p_raw + 64'd1) : p_raw;
      op2_d  = op1_q;
      tag2_d = tag1_q;
    end
    s2_valid_d = s2_valid_q;
    if (flush)          s2_valid_d = 1'b0;
    else if (s2_load)   s2_valid_d = 1'b1;
    else if (out_ready) s2_valid_d = 1'b0;
  end

  // pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      neg_q      <= 1'b0;
      op1_q      <= '0;
      tag1_q     <= '0;
      s2_valid_q <= 1'b0;
      prod_q     <= '0;
      op2_q      <= '0;
      tag2_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      mag_a_q    <= mag_a_d;
      mag_b_q    <= mag_b_d;
      neg_q      <= neg_d;
      op1_q      <= op1_d;
      tag1_q     <= tag1_d;
      s2_valid_q <= s2_valid_d;
      prod_q     <= prod_d;
      op2_q      <= op2_d;
      tag2_q     <= tag2_d;
    end
  end

  // architectural word select
  always_comb begin
    out_valid  = s2_valid_q;
    out_tag    = tag2_q;
    out_result = (op2_q == 2'b00) ? prod_q[31:0]
                                  : prod_q[63:32];
  end

endmodule

// File: tb/tb_mul_issue_pipe.sv
// Scoreboard bench for mul_issue_pipe: directed vectors,
// streaming, backpressure, flush and async reset.

module tb_mul_issue_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = '0;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_tag;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  logic [36:0] sb[$];
  int oq[$];

  mul_issue_pipe #(.TAG_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(
    input logic [1:0] op,
    input logic [31:0] a,
    input logic [31:0] b);
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] p;
    x = (op != 2'b11) ? {{32{a[31]}}, a} : {32'd0, a};
    y = (op[1] == 1'b0) ? {{32{b[31]}}, b} : {32'd0, b};
    p = x * y;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // monitor: every completed transfer is checked in order
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      oq.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_out: got %0h tag %0h expected none",
                 out_result, out_tag);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        chk("out_result", {32'd0, out_result}, {32'd0, e[36:5]});
        chk("out_tag", {59'd0, out_tag}, {59'd0, e[4:0]});
      end
    end
  end

  task automatic drive(input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] tag);
    in_valid = 1'b1;
    in_op = op;
    in_rs1 = a;
    in_rs2 = b;
    in_tag = tag;
  endtask

  task automatic send(input logic [1:0] op,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [4:0] tag,
                      input logic [31:0] exp);
    int n;
    n = 0;
    drive(op, a, b, tag);
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end else begin
      sb.push_back({exp, tag});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  logic [1:0]  s_op[8] = '{2'b00, 2'b01, 2'b10, 2'b11,
                           2'b00, 2'b01, 2'b10, 2'b11};
  logic [31:0] s_a[8] = '{32'h12345678, 32'hDEADBEEF,
                          32'h80000000, 32'hCAFEBABE,
                          32'h7FFFFFFF, 32'h00000000,
                          32'h00000005, 32'h00010000};
  logic [31:0] s_b[8] = '{32'h9ABCDEF0, 32'h01234567,
                          32'h00000002, 32'h87654321,
                          32'h7FFFFFFF, 32'hFFFFFFFF,
                          32'hFFFFFFFB, 32'h00010000};

  initial begin
    logic [31:0] hold_r;
    logic [4:0]  hold_t;
    int n;

    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_result", {32'd0, out_result}, 64'd0);
    chk("rst_out_tag", {59'd0, out_tag}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // latency of a single MUL
    send(2'b00, 32'hFFFFFFFF, 32'h00000003, 5'd9, 32'hFFFFFFFD);
    @(negedge clk);
    chk("lat_n1_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("lat_n2_valid", {63'd0, out_valid}, 64'd1);
    chk("lat_n2_tag", {59'd0, out_tag}, 64'd9);
    @(posedge clk);
    #1;

    // directed high-word and corner cases
    send(2'b01, 32'h80000000, 32'h80000000, 5'd1, 32'h40000000);
    send(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFF);
    send(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE);
    send(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'h00000001);
    send(2'b01, 32'h00000000, 32'hFFFFFFFF, 5'd5, 32'h00000000);
    repeat (4) @(posedge clk);
    #1;

    // streaming back-to-back
    oq.delete();
    for (int i = 0; i < 8; i++)
      send(s_op[i], s_a[i], s_b[i], 5'(10 + i),
           ref_mul(s_op[i], s_a[i], s_b[i]));
    n = 0;
    while (oq.size() < 8 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("stream_count", 64'(oq.size()), 64'd8);
    if (oq.size() >= 8)
      chk("stream_consec", 64'(oq[7] - oq[0]), 64'd7);

    // backpressure
    out_ready = 1'b0;
    send(2'b00, 32'd7, 32'd6, 5'd20, 32'h0000002A);
    send(2'b01, 32'hFFFFFFFE, 32'd3, 5'd21, 32'hFFFFFFFF);
    drive(2'b11, 32'h80000000, 32'd4, 5'd22);
    @(negedge clk);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
    hold_r = out_result;
    hold_t = out_tag;
    chk("bp_first_result", {32'd0, hold_r}, 64'h2A);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_hold_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_hold_result", {32'd0, out_result}, {32'd0, hold_r});
      chk("bp_hold_tag", {59'd0, out_tag}, {59'd0, hold_t});
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
    sb.push_back({32'h00000002, 5'd22});
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // flush with both stages full and a request offered
    out_ready = 1'b0;
    send(2'b00, 32'd3, 32'd3, 5'd23, 32'd9);
    send(2'b00, 32'd4, 32'd4, 5'd24, 32'd16);
    drive(2'b00, 32'd5, 32'd5, 5'd25);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_quiet", {63'd0, out_valid}, 64'd0);
    end
    @(posedge clk);
    #1;
    send(2'b10, 32'hFFFFFFFE, 32'd5, 5'd26, 32'hFFFFFFFF);
    repeat (4) @(posedge clk);
    #1;

    // async reset mid-stream
    send(2'b00, 32'd11, 32'd11, 5'd27, 32'd121);
    send(2'b00, 32'd12, 32'd12, 5'd28, 32'd144);
    send(2'b00, 32'd13, 32'd13, 5'd29, 32'd169);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    sb.delete();
    #4 rst_n = 1'b1;
    @(negedge clk);
    chk("arst_no_spurious", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    send(2'b00, 32'd1000, 32'd1000, 5'd30, 32'h000F4240);
    @(negedge clk);
    chk("arst_lat_n1", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("arst_lat_n2", {63'd0, out_valid}, 64'd1);

    // drain
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
